// File: rtl/imem_if.sv
// Instruction-memory fetch port: a single-beat request/acknowledge handshake.
// The fetch unit holds imem_req high with a stable imem_addr until the memory
// returns imem_ack together with the instruction word on imem_rdata.
interface imem_if #(
    parameter int AW = 10
) ();
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ack;
    logic [15:0]   imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC and the instruction register.
// A three-state FSM (IDLE -> FETCH -> EXEC -> FETCH ...) fetches one 16-bit
// instruction at a time, presents its decoded fields while the datapath
// executes, and selects the next PC (stack pop, taken branch, or PC+1) at the
// exec_done edge. There is no prefetch; control and flag inputs only matter
// in EXEC.
module instr_fetch_unit #(
    parameter int            AW       = 10,
    parameter logic [AW-1:0] RESET_PC = {AW{1'b0}}
) (
    input  logic          clk,
    input  logic          rst,
    imem_if.master        imem,
    output logic [5:0]    opcode,
    output logic          RA,
    output logic [1:0]    RA_stack,
    output logic [8:0]    Immediate,
    output logic          ir_valid,
    input  logic          exec_done,
    input  logic          BRA,
    input  logic          COND_BRA,
    input  logic          COND_BRA_REQUIRES_ZERO,
    input  logic          COND_BRA_REQUIRES_NEGATIVE,
    input  logic          COND_BRA_REQUIRES_CARRY,
    input  logic          COND_BRA_REQUIRES_OVERFLOW,
    input  logic          STACK_POP,
    input  logic          PC_select,
    input  logic          flag_z,
    input  logic          flag_n,
    input  logic          flag_c,
    input  logic          flag_v,
    input  logic [AW-1:0] stack_pc,
    output logic [AW-1:0] pc
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2
    } state_t;

    state_t        state_r;
    state_t        state_s;
    logic [AW-1:0] pc_r;
    logic [AW-1:0] pc_s;
    logic [15:0]   ir_r;
    logic [15:0]   ir_s;

    logic          taken_s;
    logic [AW-1:0] pc_inc_s;
    logic [AW-1:0] offset_s;
    logic [AW-1:0] next_pc_s;

    // State, PC and IR registers; asynchronous reset returns to IDLE at RESET_PC.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= S_IDLE;
            pc_r    <= RESET_PC;
            ir_r    <= 16'h0000;
        end else begin
            state_r <= state_s;
            pc_r    <= pc_s;
            ir_r    <= ir_s;
        end
    end

    // Next-PC selection: a stack pop beats a taken branch, which beats PC+1.
    // The branch offset is the 9-bit immediate sign-extended to AW bits and all
    // arithmetic wraps modulo 2^AW.
    always_comb begin
        taken_s   = ~COND_BRA
                  | (COND_BRA_REQUIRES_ZERO     & flag_z)
                  | (COND_BRA_REQUIRES_NEGATIVE & flag_n)
                  | (COND_BRA_REQUIRES_CARRY    & flag_c)
                  | (COND_BRA_REQUIRES_OVERFLOW & flag_v);
        pc_inc_s  = pc_r + AW'(1'b1);
        offset_s  = AW'($signed(ir_r[8:0]));
        next_pc_s = pc_inc_s;
        if (STACK_POP && PC_select) begin
            next_pc_s = stack_pc;
        end else if (BRA && taken_s) begin
            next_pc_s = pc_inc_s + offset_s;
        end else begin
            next_pc_s = pc_inc_s;
        end
    end

    // FSM next-state logic: capture IR on ack in FETCH, advance PC on exec_done in EXEC.
    always_comb begin
        state_s = state_r;
        pc_s    = pc_r;
        ir_s    = ir_r;
        case (state_r)
            S_IDLE: begin
                state_s = S_FETCH;
            end
            S_FETCH: begin
                if (imem.imem_ack) begin
                    ir_s    = imem.imem_rdata;
                    state_s = S_EXEC;
                end else begin
                    state_s = S_FETCH;
                end
            end
            S_EXEC: begin
                if (exec_done) begin
                    pc_s    = next_pc_s;
                    state_s = S_FETCH;
                end else begin
                    state_s = S_EXEC;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
    end

    // Outputs are pure decodes of registers, so reset removes imem_req at once.
    assign imem.imem_req  = (state_r == S_FETCH);
    assign imem.imem_addr = pc_r;
    assign ir_valid       = (state_r == S_EXEC);
    assign pc             = pc_r;
    assign opcode         = ir_r[15:10];
    assign RA             = ir_r[9];
    assign RA_stack       = ir_r[9:8];
    assign Immediate      = ir_r[8:0];

endmodule
